// File: rtl/interact_engine.sv
// interact_engine: move-request tile resolver between player control and map RAM.
// Optional stair tiles are enabled by defining INTERACT_STAIRS_EN.
module interact_engine #(
   parameter int MAP_W        = 16,
   parameter int MAP_H        = 16,
   parameter int FLOORS       = 8,
   parameter int ADDR_W       = 19,
   parameter int RAM_LAT      = 1,
   parameter int HEALTH_W     = 16,
   parameter int KEY_W        = 4,
   parameter int POTION_HP    = 50,
   parameter int MONSTER_DMG  = 30,
   parameter int START_X      = 0,
   parameter int START_Y      = 0,
   parameter int START_FLOOR  = 0,
   parameter int START_HEALTH = 100
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [3:0]          req_x,
   input  logic [3:0]          req_y,
   output logic                resp_valid,
   output logic [2:0]          resp_code,
   output logic [3:0]          player_x,
   output logic [3:0]          player_y,
   output logic [15:0]         floor,
   output logic [KEY_W-1:0]    key_num,
   output logic [HEALTH_W-1:0] health,
   output logic [ADDR_W-1:0]   ram_addr,
   output logic                ram_rd,
   input  logic [15:0]         ram_rdata,
   output logic                ram_wr,
   output logic [15:0]         ram_wdata
);

   localparam logic [2:0] C_MOVED    = 3'd0;
   localparam logic [2:0] C_WALL     = 3'd1;
   localparam logic [2:0] C_NO_KEY   = 3'd2;
   localparam logic [2:0] C_TOO_WEAK = 3'd3;
   localparam logic [2:0] C_OOB      = 3'd4;
   localparam logic [2:0] C_NOT_ADJ  = 3'd5;
   localparam logic [2:0] C_STAIRS   = 3'd6;

   localparam int CW = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

   if (RAM_LAT < 1 || FLOORS < 1) begin : g_bad_cfg
      $error("interact_engine: RAM_LAT and FLOORS must be >= 1");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_WAIT,
      S_EVAL,
      S_COMMIT
   } state_t;

   state_t state, state_nxt;

   logic [CW-1:0]       cnt;
   logic                wait_last;
   logic [15:0]         tile_q;
   logic [3:0]          tgt_x, tgt_y;
   logic                upd_q;
   logic                wr_q;
   logic [3:0]          n_x, n_y;
   logic [15:0]         n_floor;
   logic [KEY_W-1:0]    n_key;
   logic [HEALTH_W-1:0] n_health;

   logic                oob;
   logic                adj;
   logic                x_step, y_step;
   logic [31:0]         addr_full;
   logic [HEALTH_W:0]   hsum;

   logic [2:0]          e_code;
   logic [3:0]          e_x, e_y;
   logic [15:0]         e_floor;
   logic [KEY_W-1:0]    e_key;
   logic [HEALTH_W-1:0] e_health;
   logic                e_wr;
   logic [15:0]         e_tile;

   assign wait_last = (cnt == CW'(RAM_LAT - 1));

   assign oob = (32'(req_x) >= MAP_W) ||
                (32'(req_y) >= MAP_H);

   assign x_step = ({1'b0, req_x} == {1'b0, player_x} + 5'd1) ||
                   ({1'b0, player_x} == {1'b0, req_x} + 5'd1);
   assign y_step = ({1'b0, req_y} == {1'b0, player_y} + 5'd1) ||
                   ({1'b0, player_y} == {1'b0, req_y} + 5'd1);
   assign adj = (x_step && (req_y == player_y)) ||
                (y_step && (req_x == player_x));

   assign addr_full = 32'(floor) * 32'(MAP_W * MAP_H) +
                      32'(req_y) * 32'(MAP_W) +
                      32'(req_x);

   assign hsum = {1'b0, health} + (HEALTH_W+1)'(POTION_HP);

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state decode
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:
            if (req_valid)
               state_nxt = (oob || !adj) ? S_COMMIT : S_READ;
         S_READ:   state_nxt = S_WAIT;
         S_WAIT:   if (wait_last) state_nxt = S_EVAL;
         S_EVAL:   state_nxt = S_COMMIT;
         S_COMMIT: state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Handshake and RAM strobes decoded from state
   always_comb begin
      req_ready  = (state == S_IDLE);
      ram_rd     = (state == S_READ);
      resp_valid = (state == S_COMMIT);
      ram_wr     = (state == S_COMMIT) && wr_q;
   end

   // Tile resolution: defaults leave the player where they are
   always_comb begin
      e_code   = C_WALL;
      e_x      = player_x;
      e_y      = player_y;
      e_floor  = floor;
      e_key    = key_num;
      e_health = health;
      e_wr     = 1'b0;
      e_tile   = 16'd0;
      case (tile_q)
         16'd0: begin
            e_code = C_MOVED;
            e_x    = tgt_x;
            e_y    = tgt_y;
         end
         16'd2: begin
            e_code = C_MOVED;
            e_x    = tgt_x;
            e_y    = tgt_y;
            e_wr   = 1'b1;
            if (key_num != {KEY_W{1'b1}})
               e_key = key_num + KEY_W'(1);
         end
         16'd3: begin
            if (key_num != '0) begin
               e_code = C_MOVED;
               e_x    = tgt_x;
               e_y    = tgt_y;
               e_wr   = 1'b1;
               e_key  = key_num - KEY_W'(1);
            end else begin
               e_code = C_NO_KEY;
            end
         end
         16'd4: begin
            e_code   = C_MOVED;
            e_x      = tgt_x;
            e_y      = tgt_y;
            e_wr     = 1'b1;
            e_health = hsum[HEALTH_W] ? {HEALTH_W{1'b1}}
                                      : hsum[HEALTH_W-1:0];
         end
         16'd5: begin
            if (health > HEALTH_W'(MONSTER_DMG)) begin
               e_code   = C_MOVED;
               e_x      = tgt_x;
               e_y      = tgt_y;
               e_wr     = 1'b1;
               e_health = health - HEALTH_W'(MONSTER_DMG);
            end else begin
               e_code = C_TOO_WEAK;
            end
         end
`ifdef INTERACT_STAIRS_EN
         16'd6: begin
            if (floor < 16'(FLOORS - 1)) begin
               e_code  = C_STAIRS;
               e_floor = floor + 16'd1;
            end
         end
         16'd7: begin
            if (floor != 16'd0) begin
               e_code  = C_STAIRS;
               e_floor = floor - 16'd1;
            end
         end
`else
         16'd6, 16'd7: e_code = C_WALL;
`endif
         default: e_code = C_WALL;
      endcase
   end

   // Request latch, RAM address, wait counter, resolved result and player state
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         tile_q    <= '0;
         tgt_x     <= '0;
         tgt_y     <= '0;
         upd_q     <= 1'b0;
         wr_q      <= 1'b0;
         resp_code <= '0;
         ram_addr  <= '0;
         ram_wdata <= '0;
         n_x       <= '0;
         n_y       <= '0;
         n_floor   <= '0;
         n_key     <= '0;
         n_health  <= '0;
         player_x  <= 4'(START_X);
         player_y  <= 4'(START_Y);
         floor     <= 16'(START_FLOOR);
         key_num   <= '0;
         health    <= HEALTH_W'(START_HEALTH);
      end else begin
         unique case (state)
            S_IDLE: begin
               if (req_valid) begin
                  tgt_x <= req_x;
                  tgt_y <= req_y;
                  upd_q <= 1'b0;
                  wr_q  <= 1'b0;
                  if (oob)
                     resp_code <= C_OOB;
                  else if (!adj)
                     resp_code <= C_NOT_ADJ;
                  else
                     ram_addr <= addr_full[ADDR_W-1:0];
               end
            end
            S_READ: cnt <= '0;
            S_WAIT: begin
               cnt <= cnt + CW'(1);
               if (wait_last) tile_q <= ram_rdata;
            end
            S_EVAL: begin
               resp_code <= e_code;
               wr_q      <= e_wr;
               ram_wdata <= e_tile;
               upd_q     <= 1'b1;
               n_x       <= e_x;
               n_y       <= e_y;
               n_floor   <= e_floor;
               n_key     <= e_key;
               n_health  <= e_health;
            end
            S_COMMIT: begin
               if (upd_q) begin
                  player_x <= n_x;
                  player_y <= n_y;
                  floor    <= n_floor;
                  key_num  <= n_key;
                  health   <= n_health;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_interact_engine.sv
// tb_interact_engine: directed checks of interact_engine with a 2-cycle map RAM.
// Stair expectations follow INTERACT_STAIRS_EN.
module tb_interact_engine;

   localparam int AW = 19;
`ifdef INTERACT_STAIRS_EN
   localparam bit SE = 1'b1;
`else
   localparam bit SE = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid;
   logic          req_ready;
   logic [3:0]    req_x, req_y;
   logic          resp_valid;
   logic [2:0]    resp_code;
   logic [3:0]    player_x, player_y;
   logic [15:0]   floor;
   logic [3:0]    key_num;
   logic [15:0]   health;
   logic [AW-1:0] ram_addr;
   logic          ram_rd;
   logic [15:0]   ram_rdata;
   logic          ram_wr;
   logic [15:0]   ram_wdata;

   int errors = 0;
   int checks = 0;

   logic [15:0] mem [0:1023];
   logic        tb_we;
   logic [9:0]  tb_wa;
   logic [15:0] tb_wd;
   logic [15:0] p0, p1;

   always #5 clk = ~clk;

   interact_engine #(
      .MAP_W(10), .MAP_H(10), .FLOORS(8), .ADDR_W(AW),
      .RAM_LAT(2), .HEALTH_W(16), .KEY_W(4),
      .POTION_HP(65490), .MONSTER_DMG(30),
      .START_X(0), .START_Y(0), .START_FLOOR(0),
      .START_HEALTH(90)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_x(req_x), .req_y(req_y),
      .resp_valid(resp_valid), .resp_code(resp_code),
      .player_x(player_x), .player_y(player_y),
      .floor(floor), .key_num(key_num), .health(health),
      .ram_addr(ram_addr), .ram_rd(ram_rd),
      .ram_rdata(ram_rdata), .ram_wr(ram_wr),
      .ram_wdata(ram_wdata)
   );

   // Two-stage read pipeline; idle cycles return an illegal tile
   always @(posedge clk) begin
      p0 <= ram_rd ? mem[ram_addr[9:0]] : 16'hFFFF;
      p1 <= p0;
      if (tb_we)
         mem[tb_wa] <= tb_wd;
      else if (ram_wr)
         mem[ram_addr[9:0]] <= ram_wdata;
   end
   assign ram_rdata = p1;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic poke(input logic [9:0] a, input logic [15:0] d);
      @(negedge clk);
      tb_we = 1'b1;
      tb_wa = a;
      tb_wd = d;
      @(negedge clk);
      tb_we = 1'b0;
   endtask

   task automatic pchk(input string nm,
                       input int x, input int y, input int f,
                       input int k, input int h);
      chk({nm, "/x"}, 32'(player_x), 32'(x));
      chk({nm, "/y"}, 32'(player_y), 32'(y));
      chk({nm, "/floor"}, 32'(floor), 32'(f));
      chk({nm, "/keys"}, 32'(key_num), 32'(k));
      chk({nm, "/health"}, 32'(health), 32'(h));
   endtask

   task automatic mv(input string nm,
                     input logic [3:0] x, input logic [3:0] y,
                     input logic [2:0] ecode, input bit acc,
                     input bit ew, input int eaddr);
      int rc, rdc, rdn, stray;
      logic gw;
      logic [2:0] gc;
      logic [15:0] gwd;
      logic [AW-1:0] ga;
      @(negedge clk);
      chk({nm, "/ready"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_x = x;
      req_y = y;
      @(posedge clk);
      #1 req_valid = 1'b0;
      rc = -1; rdc = -1; rdn = 0; stray = 0;
      gw = 1'b0; gc = '0; gwd = '0; ga = '0;
      for (int c = 1; c <= 12 && rc < 0; c++) begin
         @(negedge clk);
         if (ram_rd) begin
            rdn++;
            if (rdc < 0) rdc = c;
         end
         if (ram_wr && !resp_valid) stray++;
         if (resp_valid) begin
            rc  = c;
            gc  = resp_code;
            gw  = ram_wr;
            gwd = ram_wdata;
            ga  = ram_addr;
         end
      end
      chk({nm, "/resp_cycle"}, 32'(rc), acc ? 32'd5 : 32'd1);
      chk({nm, "/code"}, 32'(gc), 32'(ecode));
      chk({nm, "/rd_count"}, 32'(rdn), acc ? 32'd1 : 32'd0);
      chk({nm, "/stray_wr"}, 32'(stray), 32'd0);
      chk({nm, "/wr"}, 32'(gw), 32'(ew));
      if (acc) begin
         chk({nm, "/rd_cycle"}, 32'(rdc), 32'd1);
         chk({nm, "/addr"}, 32'(ga), 32'(eaddr));
      end
      if (ew) chk({nm, "/wdata"}, 32'(gwd), 32'd0);
      @(negedge clk);
   endtask

   initial begin
      int bad;
      rst = 1'b1;
      req_valid = 1'b0;
      req_x = '0;
      req_y = '0;
      tb_we = 1'b0;
      tb_wa = '0;
      tb_wd = '0;
      poke(10'd10, 16'd3);
      poke(10'd1,  16'd2);
      poke(10'd2,  16'd3);
      poke(10'd3,  16'd5);
      poke(10'd4,  16'd5);
      poke(10'd5,  16'd5);
      poke(10'd14, 16'd4);
      poke(10'd15, 16'd4);
      poke(10'd16, 16'd1);
      poke(10'd25, 16'd9);
      @(negedge clk);
      chk("rst/ready", 32'(req_ready), 32'd1);
      chk("rst/resp_valid", 32'(resp_valid), 32'd0);
      chk("rst/ram_rd", 32'(ram_rd), 32'd0);
      chk("rst/ram_wr", 32'(ram_wr), 32'd0);
      chk("rst/resp_code", 32'(resp_code), 32'd0);
      chk("rst/ram_addr", 32'(ram_addr), 32'd0);
      chk("rst/ram_wdata", 32'(ram_wdata), 32'd0);
      pchk("rst", 0, 0, 0, 0, 90);
      rst = 1'b0;

      mv("diag", 4'd3, 4'd3, 3'd5, 1'b0, 1'b0, 0);
      mv("self", 4'd0, 4'd0, 3'd5, 1'b0, 1'b0, 0);
      mv("oob_x", 4'd10, 4'd0, 3'd4, 1'b0, 1'b0, 0);
      mv("oob_y", 4'd0, 4'd10, 3'd4, 1'b0, 1'b0, 0);
      pchk("rej", 0, 0, 0, 0, 90);

      mv("door0", 4'd0, 4'd1, 3'd2, 1'b1, 1'b0, 10);
      pchk("door0", 0, 0, 0, 0, 90);
      mv("key", 4'd1, 4'd0, 3'd0, 1'b1, 1'b1, 1);
      pchk("key", 1, 0, 0, 1, 90);
      mv("door1", 4'd2, 4'd0, 3'd0, 1'b1, 1'b1, 2);
      pchk("door1", 2, 0, 0, 0, 90);

      mv("mon1", 4'd3, 4'd0, 3'd0, 1'b1, 1'b1, 3);
      pchk("mon1", 3, 0, 0, 0, 60);
      mv("mon2", 4'd4, 4'd0, 3'd0, 1'b1, 1'b1, 4);
      pchk("mon2", 4, 0, 0, 0, 30);
      mv("weak", 4'd5, 4'd0, 3'd3, 1'b1, 1'b0, 5);
      pchk("weak", 4, 0, 0, 0, 30);

      mv("pot1", 4'd4, 4'd1, 3'd0, 1'b1, 1'b1, 14);
      pchk("pot1", 4, 1, 0, 0, 65520);
      mv("pot2", 4'd5, 4'd1, 3'd0, 1'b1, 1'b1, 15);
      pchk("pot2", 5, 1, 0, 0, 65535);

      mv("wall", 4'd6, 4'd1, 3'd1, 1'b1, 1'b0, 16);
      mv("tile9", 4'd5, 4'd2, 3'd1, 1'b1, 1'b0, 25);
      pchk("wall", 5, 1, 0, 0, 65535);

      poke(10'd14, 16'd6);
      poke(10'd114, 16'd7);
      mv("up", 4'd4, 4'd1, SE ? 3'd6 : 3'd1, 1'b1, 1'b0, 14);
      pchk("up", 5, 1, SE ? 1 : 0, 0, 65535);
      mv("down", 4'd4, 4'd1, SE ? 3'd6 : 3'd1, 1'b1, 1'b0,
         SE ? 114 : 14);
      pchk("down", 5, 1, 0, 0, 65535);

      @(negedge clk);
      req_valid = 1'b1;
      req_x = 4'd4;
      req_y = 4'd1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("mid_rst/ready", 32'(req_ready), 32'd1);
      chk("mid_rst/resp_valid", 32'(resp_valid), 32'd0);
      chk("mid_rst/ram_wr", 32'(ram_wr), 32'd0);
      pchk("mid_rst", 0, 0, 0, 0, 90);
      bad = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (resp_valid || ram_wr || ram_rd) bad++;
      end
      chk("mid_rst/quiet", 32'(bad), 32'd0);

      mv("floor_tile", 4'd1, 4'd0, 3'd0, 1'b1, 1'b0, 1);
      pchk("floor_tile", 1, 0, 0, 0, 90);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

endmodule
